// File: rtl/serial_to_parallel.sv
// serial_to_parallel: MSB-first serial-to-parallel converter with a valid/ready output and a sticky overrun flag
module serial_to_parallel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic IDLE = 1'b0;
  localparam logic SHIFT = 1'b1;
  logic state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] nxt;
  logic done;
  assign nxt = {sr[WIDTH-2:0], serial_in};
  assign done = state == SHIFT && !start && serial_valid && cnt == CW'(WIDTH - 1);
  assign busy = state == SHIFT;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      parallel_out <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (start) begin
        state <= SHIFT;
        cnt <= '0;
        sr <= '0;
      end else if (state == SHIFT && serial_valid) begin
        sr <= nxt;
        state <= done ? IDLE : SHIFT;
        cnt <= done ? '0 : cnt + 1'b1;
      end
      // a completing word always wins over a same-cycle consume
      if (done) begin
        parallel_out <= nxt;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel: directed frames with a scoreboard of expected accepted words
module tb_serial_to_parallel;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic serial_in = 1'b0;
  logic serial_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] parallel_out;
  logic out_valid, busy, overrun;
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  serial_to_parallel #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .serial_in(serial_in),
    .serial_valid(serial_valid), .out_ready(out_ready), .parallel_out(parallel_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    serial_valid = 1'b1;
    serial_in = b;
    tick();
    serial_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 7; i >= 0; i--) begin
      if (i == 3)
        repeat (gap) begin
          @(negedge clk);
          chk("gap_busy", 32'(busy), 1);
          tick();
        end
      send_bit(w[i]);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL accept_unexpected got %0h expected none", parallel_out);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({overrun, parallel_out} !== e) begin
          errors++;
          $display("FAIL accept_word got ovr=%0b data=%0h expected ovr=%0b data=%0h",
                   overrun, parallel_out, e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_data", 32'(parallel_out), 0);
    chk("reset_overrun", 32'(overrun), 0);
    reset = 1'b0;
    tick();
    // basic frame
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'hA5});
    do_start();
    @(negedge clk);
    chk("start_busy", 32'(busy), 1);
    send_word(8'hA5, 0);
    @(negedge clk);
    chk("f1_valid", 32'(out_valid), 1);
    chk("f1_data", 32'(parallel_out), 32'hA5);
    chk("f1_busy", 32'(busy), 0);
    chk("f1_overrun", 32'(overrun), 0);
    tick();
    @(negedge clk);
    chk("f1_consumed", 32'(out_valid), 0);
    // gap of three idle cycles mid-frame
    exp_q.push_back({1'b0, 8'hA5});
    do_start();
    send_word(8'hA5, 3);
    @(negedge clk);
    chk("gap_data", 32'(parallel_out), 32'hA5);
    tick();
    // overrun: first word never consumed
    out_ready = 1'b0;
    do_start();
    send_word(8'hA5, 0);
    @(negedge clk);
    chk("ovr_hold_data", 32'(parallel_out), 32'hA5);
    tick();
    @(negedge clk);
    chk("ovr_hold_valid", 32'(out_valid), 1);
    do_start();
    send_word(8'h3C, 0);
    @(negedge clk);
    chk("ovr_data", 32'(parallel_out), 32'h3C);
    chk("ovr_flag", 32'(overrun), 1);
    exp_q.push_back({1'b1, 8'h3C});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("ovr_sticky", 32'(overrun), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_overrun", 32'(overrun), 0);
    tick();
    reset = 1'b0;
    tick();
    // consume in the same cycle a new word completes
    do_start();
    send_word(8'hA5, 0);
    do_start();
    for (int i = 7; i >= 1; i--) send_bit(8'h3C >> i);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h3C});
    out_ready = 1'b1;
    send_bit(1'b0);
    @(negedge clk);
    chk("same_cycle_data", 32'(parallel_out), 32'h3C);
    chk("same_cycle_valid", 32'(out_valid), 1);
    chk("same_cycle_overrun", 32'(overrun), 0);
    tick();
    // restart aborts a partial frame; the bit beside start is ignored
    do_start();
    repeat (4) send_bit(1'b1);
    serial_valid = 1'b1;
    serial_in = 1'b1;
    do_start();
    serial_valid = 1'b0;
    exp_q.push_back({1'b0, 8'h0F});
    send_word(8'h0F, 0);
    @(negedge clk);
    chk("abort_data", 32'(parallel_out), 32'h0F);
    tick();
    // reset mid-frame, then bits without start are ignored
    do_start();
    repeat (5) send_bit(1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_data", 32'(parallel_out), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      @(negedge clk);
      chk("nostart_valid", 32'(out_valid), 0);
      chk("nostart_busy", 32'(busy), 0);
    end
    tick();
    exp_q.push_back({1'b0, 8'h81});
    do_start();
    send_word(8'h81, 0);
    @(negedge clk);
    chk("post_reset_data", 32'(parallel_out), 32'h81);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 The block SHALL have a parameter: WIDTH, default 8, the number of bits per word (minimum 2).
REQ-002 The block SHALL have a port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have a port: reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have a port: start  input  1  begin or restart a frame.
REQ-005 The block SHALL have a port: serial_in  input  1  serial data bit, MSB first.
REQ-006 The block SHALL have a port: serial_valid  input  1  serial_in is sampled this cycle.
REQ-007 The block SHALL have a port: out_ready  input  1  consumer accepts parallel_out this cycle.
REQ-008 The block SHALL have a port: parallel_out  output  WIDTH  last completed word.
REQ-009 The block SHALL have a port: out_valid  output  1  parallel_out holds an unconsumed word.
REQ-010 The block SHALL have a port: busy  output  1  a frame is in progress (state SHIFT).
REQ-011 The block SHALL have a port: overrun  output  1  sticky flag; a word completed while the previous word was unconsumed.

Function
REQ-012 The FSM SHALL have states IDLE and SHIFT; busy SHALL be 1 exactly in SHIFT.
REQ-013 IDLE, start=1: next state SHIFT; bit counter <= 0; shift register <= 0; serial_valid in the same cycle SHALL be ignored.
REQ-014 SHIFT, serial_valid=1: shift register <= {shift_reg[WIDTH-2:0], serial_in}; counter +1; the first accepted bit SHALL end up as bit WIDTH-1 (MSB first).
REQ-015 SHIFT, serial_valid=0: shift register and counter SHALL hold; gaps of any length are allowed.
REQ-016 Word completion: in SHIFT, serial_valid=1 with counter==WIDTH-1 -> next edge parallel_out <= {shift_reg[WIDTH-2:0], serial_in}, out_valid <= 1, state <= IDLE, counter <= 0.
REQ-017 Latency: out_valid SHALL rise on the clock edge that samples the last bit; it is visible in the following cycle.
REQ-018 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never exceed WIDTH-1 in SHIFT.
REQ-019 Handshake: out_valid=1 and out_ready=1 -> out_valid <= 0 next edge; parallel_out SHALL stay stable while out_valid=1 and not accepted.
REQ-020 Completion while out_valid=1 and out_ready=0: parallel_out SHALL be overwritten with the new word, out_valid stays 1, overrun <= 1.
REQ-021 Completion while out_valid=1 and out_ready=1 in the same cycle: the new word SHALL load, out_valid stays 1, and overrun is unchanged.
REQ-022 start=1 in SHIFT: the partial frame SHALL be discarded (counter <= 0, shift register <= 0), state stays SHIFT, and the bit on serial_in that cycle SHALL be ignored; out_valid/parallel_out SHALL be unaffected.
REQ-023 serial_valid in IDLE (without start) SHALL be ignored.
REQ-024 overrun SHALL clear only on reset.

Reset
REQ-025 reset=1 SHALL immediately force: state IDLE, counter 0, shift register 0, parallel_out 0, out_valid 0, busy 0, overrun 0.
REQ-026 Reset mid-frame SHALL discard the partial word; after deassertion, the block SHALL require start before accepting bits.

Verification
REQ-027 WIDTH=8; start, then bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles with serial_valid=1 -> parallel_out=0xA5, out_valid=1 one cycle after the last bit, busy=0, overrun=0.
REQ-028 Same frame with serial_valid deasserted for 3 cycles between bits 4 and 5 -> result 0xA5; busy=1 throughout the gap.
REQ-029 Frame 0xA5 left unconsumed (out_ready=0), then frame 0x3C -> parallel_out=0x3C, out_valid=1, overrun=1.
REQ-030 out_ready=1 in the same cycle the second frame completes -> parallel_out=0x3C, out_valid=1, overrun=0.
REQ-031 start after 4 bits of 0xFF, then full frame 0x0F -> parallel_out=0x0F, with no residue from the aborted bits.
REQ-032 reset asserted after 5 bits; after release, send 8 bits without start -> out_valid stays 0, busy stays 0; then start + 0x81 -> parallel_out=0x81.
